// File: rtl/control_sequencer.sv
// control_sequencer: FETCH/EXEC/HALT instruction sequencer for a register-file/ALU datapath.
// The IR is latched in FETCH.
// The control word, constant and memory strobe are decoded only from the latched IR and the
// current state, so IR_in never reaches CTRWRD combinationally.
module control_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [15:0] PC_out,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic [15:0] IR_in,
  output logic [15:0] CTRWRD,
  output logic [15:0] Cin,
  output logic        mem_write,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic        halted
);

  // Opcode map (IR[15:9])
  localparam logic [6:0] OP_MOVA = 7'b0000000;
  localparam logic [6:0] OP_INC  = 7'b0000001;
  localparam logic [6:0] OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_SUB  = 7'b0000101;
  localparam logic [6:0] OP_DEC  = 7'b0000110;
  localparam logic [6:0] OP_AND  = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001;
  localparam logic [6:0] OP_XOR  = 7'b0001010;
  localparam logic [6:0] OP_NOT  = 7'b0001011;
  localparam logic [6:0] OP_MOVB = 7'b0001100;
  localparam logic [6:0] OP_ADI  = 7'b1000010;
  localparam logic [6:0] OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000;
  localparam logic [6:0] OP_BRZ  = 7'b1100000;
  localparam logic [6:0] OP_BRN  = 7'b1100001;
  localparam logic [6:0] OP_HLT  = 7'b1111111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] w_pc_next;
  logic [15:0] r_ir;
  logic [15:0] w_ir_next;

  // Instruction fields of the latched IR
  logic [6:0]  w_opcode;
  logic [2:0]  w_dr;
  logic [2:0]  w_sa;
  logic [2:0]  w_sb;
  logic [15:0] w_br_offset;

  assign w_opcode    = r_ir[15:9];
  assign w_dr        = r_ir[8:6];
  assign w_sa        = r_ir[5:3];
  assign w_sb        = r_ir[2:0];
  // Branch displacement is the 6-bit two's-complement value {DR,SB}, sign-extended
  assign w_br_offset = {{10{w_dr[2]}}, w_dr, w_sb};

  // Overflow and carry status are not used by any branch condition
  logic w_unused_status;
  assign w_unused_status = V ^ C;

  assign PC_out = r_pc;

  // State, PC and IR registers; RESET wins over any in-flight fetch or branch
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  // Next-state, next-PC and decoded datapath controls
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    CTRWRD       = 16'h0000;
    Cin          = 16'h0000;
    mem_write    = 1'b0;
    fetch_req    = 1'b0;
    halted       = 1'b0;

    case (r_state)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          w_ir_next    = IR_in;
          w_state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        w_state_next = S_FETCH;
        w_pc_next    = r_pc + 16'd1;
        case (w_opcode)
          OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC,
          OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOVB: begin
            // FS is taken straight from the low opcode bits
            CTRWRD = {w_dr, w_sa, w_sb, 1'b0, w_opcode[3:0], 1'b0, 1'b1};
          end
          OP_ADI: begin
            CTRWRD = {w_dr, w_sa, 3'b000, 1'b1, 4'b0010, 1'b0, 1'b1};
            Cin    = {13'b0, w_sb};
          end
          OP_LD: begin
            CTRWRD = {w_dr, w_sa, 3'b000, 1'b0, 4'b0000, 1'b1, 1'b1};
          end
          OP_ST: begin
            CTRWRD    = {3'b000, w_sa, w_sb, 1'b0, 4'b0000, 1'b0, 1'b0};
            mem_write = 1'b1;
          end
          OP_BRZ: begin
            // Pass A through the ALU so Z/N reflect register SA
            CTRWRD = {3'b000, w_sa, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0};
            if (Z) begin
              w_pc_next = r_pc + w_br_offset;
            end
          end
          OP_BRN: begin
            CTRWRD = {3'b000, w_sa, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0};
            if (N) begin
              w_pc_next = r_pc + w_br_offset;
            end
          end
          OP_HLT: begin
            // Freeze PC on the HLT instruction itself
            w_pc_next    = r_pc;
            w_state_next = S_HALT;
          end
          default: begin
            // Unassigned opcodes execute as NOP
          end
        endcase
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer.
// Inputs are driven and outputs sampled at the falling edge.
module tb_control_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] PC_out;
  logic        fetch_req;
  logic        fetch_ack;
  logic [15:0] IR_in;
  logic [15:0] CTRWRD;
  logic [15:0] Cin;
  logic        mem_write;
  logic        V, C, N, Z;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  control_sequencer #(.RESET_PC(16'h0000)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .PC_out   (PC_out),
    .fetch_req(fetch_req),
    .fetch_ack(fetch_ack),
    .IR_in    (IR_in),
    .CTRWRD   (CTRWRD),
    .Cin      (Cin),
    .mem_write(mem_write),
    .V        (V),
    .C        (C),
    .N        (N),
    .Z        (Z),
    .halted   (halted)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  // From FETCH: present one instruction with ack, land in its EXEC cycle
  task automatic issue(input logic [15:0] ir);
    fetch_ack = 1'b1;
    IR_in     = ir;
    @(negedge CLK);
    fetch_ack = 1'b0;
    IR_in     = 16'h0000;
    $display("exec pc=%h ir=%h ctrwrd=%h cin=%h memw=%b", PC_out, ir, CTRWRD, Cin, mem_write);
  endtask

  task automatic test_reset;
    RESET = 1'b1; fetch_ack = 1'b0; IR_in = 16'h0000;
    V = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0;
    repeat (2) tick();
    RESET = 1'b0;
    n_cmp++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h exp 0000", PC_out); end
    n_cmp++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_req: got %b exp 1", fetch_req); end
    n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL rst_ctrwrd: got %h exp 0000", CTRWRD); end
    n_cmp++; if (Cin !== 16'h0000) begin n_fail++; $display("FAIL rst_cin: got %h exp 0000", Cin); end
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_memw: got %b exp 0", mem_write); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b exp 0", halted); end
  endtask

  task automatic test_alu;
    issue(16'h0501);  // ADD R4,R0,R1
    n_cmp++; if (CTRWRD !== 16'h8089) begin n_fail++; $display("FAIL add_ctrwrd: got %h exp 8089", CTRWRD); end
    n_cmp++; if (Cin !== 16'h0000) begin n_fail++; $display("FAIL add_cin: got %h exp 0000", Cin); end
    n_cmp++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL add_fetch_req: got %b exp 0", fetch_req); end
    n_cmp++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL add_exec_pc: got %h exp 0000", PC_out); end
    tick();
    n_cmp++; if (PC_out !== 16'h0001) begin n_fail++; $display("FAIL add_next_pc: got %h exp 0001", PC_out); end
    n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL add_fetch_ctrwrd: got %h exp 0000", CTRWRD); end
    issue(16'h17D8);  // NOT R7,R3
    n_cmp++; if (CTRWRD !== 16'hEC2D) begin n_fail++; $display("FAIL not_ctrwrd: got %h exp EC2D", CTRWRD); end
    tick();
  endtask

  task automatic test_adi;
    issue(16'h849D);  // ADI R2,R3,#5
    n_cmp++; if (CTRWRD !== 16'h4C49) begin n_fail++; $display("FAIL adi_ctrwrd: got %h exp 4C49", CTRWRD); end
    n_cmp++; if (Cin !== 16'h0005) begin n_fail++; $display("FAIL adi_cin: got %h exp 0005", Cin); end
    tick();
    n_cmp++; if (Cin !== 16'h0000) begin n_fail++; $display("FAIL adi_fetch_cin: got %h exp 0000", Cin); end
    n_cmp++; if (PC_out !== 16'h0003) begin n_fail++; $display("FAIL adi_next_pc: got %h exp 0003", PC_out); end
  endtask

  task automatic test_load_store;
    issue(16'h2050);  // LD R1,[R2]
    n_cmp++; if (CTRWRD !== 16'h2803) begin n_fail++; $display("FAIL ld_ctrwrd: got %h exp 2803", CTRWRD); end
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL ld_memw: got %b exp 0", mem_write); end
    tick();
    issue(16'h4035);  // ST [R6] <- R5
    n_cmp++; if (CTRWRD !== 16'h1A80) begin n_fail++; $display("FAIL st_ctrwrd: got %h exp 1A80", CTRWRD); end
    n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL st_memw: got %b exp 1", mem_write); end
    tick();
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL st_memw_after: got %b exp 0", mem_write); end
    n_cmp++; if (PC_out !== 16'h0005) begin n_fail++; $display("FAIL st_next_pc: got %h exp 0005", PC_out); end
  endtask

  task automatic test_nop;
    issue(16'h71FF);  // unassigned opcode 0111000
    n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL nop_ctrwrd: got %h exp 0000", CTRWRD); end
    n_cmp++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL nop_fetch_req: got %b exp 0", fetch_req); end
    tick();
    n_cmp++; if (PC_out !== 16'h0006) begin n_fail++; $display("FAIL nop_next_pc: got %h exp 0006", PC_out); end
  endtask

  task automatic test_branch;
    repeat (4) begin issue(16'h71FF); tick(); end
    n_cmp++; if (PC_out !== 16'h000A) begin n_fail++; $display("FAIL br_setup_pc: got %h exp 000A", PC_out); end
    issue(16'hC1CE); Z = 1'b1;  // BRZ R1,-2 taken
    n_cmp++; if (CTRWRD !== 16'h0400) begin n_fail++; $display("FAIL brz_ctrwrd: got %h exp 0400", CTRWRD); end
    tick(); Z = 1'b0;
    n_cmp++; if (PC_out !== 16'h0008) begin n_fail++; $display("FAIL brz_taken_pc: got %h exp 0008", PC_out); end
    repeat (2) begin issue(16'h71FF); tick(); end
    issue(16'hC1CE); Z = 1'b0; N = 1'b1;  // BRZ not taken, N must not matter
    tick(); N = 1'b0;
    n_cmp++; if (PC_out !== 16'h000B) begin n_fail++; $display("FAIL brz_not_taken_pc: got %h exp 000B", PC_out); end
    issue(16'hC3CE); N = 1'b1;  // BRN R1,-2 taken
    n_cmp++; if (CTRWRD !== 16'h0400) begin n_fail++; $display("FAIL brn_ctrwrd: got %h exp 0400", CTRWRD); end
    tick(); N = 1'b0;
    n_cmp++; if (PC_out !== 16'h0009) begin n_fail++; $display("FAIL brn_taken_pc: got %h exp 0009", PC_out); end
    issue(16'hC005); Z = 1'b1;  // BRZ R0,+5 taken
    tick(); Z = 1'b0;
    n_cmp++; if (PC_out !== 16'h000E) begin n_fail++; $display("FAIL brz_fwd_pc: got %h exp 000E", PC_out); end
    issue(16'hC3CE); Z = 1'b1;  // BRN not taken, Z must not matter
    tick(); Z = 1'b0;
    n_cmp++; if (PC_out !== 16'h000F) begin n_fail++; $display("FAIL brn_not_taken_pc: got %h exp 000F", PC_out); end
  endtask

  task automatic test_stall;
    fetch_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL stall_fetch_req[%0d]: got %b exp 1", k, fetch_req); end
      n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL stall_ctrwrd[%0d]: got %h exp 0000", k, CTRWRD); end
      n_cmp++; if (PC_out !== 16'h000F) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h exp 000F", k, PC_out); end
    end
    issue(16'h0501);
    n_cmp++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL stall_ack_exec: got %b exp 0", fetch_req); end
    n_cmp++; if (CTRWRD !== 16'h8089) begin n_fail++; $display("FAIL stall_ack_ctrwrd: got %h exp 8089", CTRWRD); end
    tick();
  endtask

  task automatic test_back_to_back;
    fetch_ack = 1'b1; IR_in = 16'h849D;
    tick();  // EXEC ADI at PC 16
    IR_in = 16'h0501;  // offered during EXEC, must be ignored
    n_cmp++; if (CTRWRD !== 16'h4C49) begin n_fail++; $display("FAIL b2b_adi_ctrwrd: got %h exp 4C49", CTRWRD); end
    tick();
    n_cmp++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL b2b_fetch_req: got %b exp 1", fetch_req); end
    n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL b2b_fetch_ctrwrd: got %h exp 0000", CTRWRD); end
    n_cmp++; if (PC_out !== 16'h0011) begin n_fail++; $display("FAIL b2b_pc: got %h exp 0011", PC_out); end
    IR_in = 16'h17D8;
    tick();
    n_cmp++; if (CTRWRD !== 16'hEC2D) begin n_fail++; $display("FAIL b2b_not_ctrwrd: got %h exp EC2D", CTRWRD); end
    fetch_ack = 1'b0; IR_in = 16'h0000;
    tick();
    n_cmp++; if (PC_out !== 16'h0012) begin n_fail++; $display("FAIL b2b_end_pc: got %h exp 0012", PC_out); end
  endtask

  task automatic test_wrap;
    RESET = 1'b1; tick(); RESET = 1'b0;
    issue(16'hC1CE); Z = 1'b1;  // 0 - 2
    tick(); Z = 1'b0;
    n_cmp++; if (PC_out !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_back_pc: got %h exp FFFE", PC_out); end
    issue(16'h71FF); tick();
    n_cmp++; if (PC_out !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff_pc: got %h exp FFFF", PC_out); end
    issue(16'h71FF); tick();
    n_cmp++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero_pc: got %h exp 0000", PC_out); end
  endtask

  task automatic test_halt;
    issue(16'h71FF); tick();  // PC 1
    issue(16'hFE00);
    n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL hlt_ctrwrd: got %h exp 0000", CTRWRD); end
    tick();
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hlt_halted: got %b exp 1", halted); end
    n_cmp++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL hlt_fetch_req: got %b exp 0", fetch_req); end
    n_cmp++; if (PC_out !== 16'h0001) begin n_fail++; $display("FAIL hlt_pc: got %h exp 0001", PC_out); end
    fetch_ack = 1'b1; IR_in = 16'h0501;
    repeat (3) tick();
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hlt_stay: got %b exp 1", halted); end
    n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL hlt_stay_ctrwrd: got %h exp 0000", CTRWRD); end
    n_cmp++; if (PC_out !== 16'h0001) begin n_fail++; $display("FAIL hlt_stay_pc: got %h exp 0001", PC_out); end
    RESET = 1'b1; tick(); RESET = 1'b0; fetch_ack = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hlt_rst_halted: got %b exp 0", halted); end
    n_cmp++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL hlt_rst_fetch_req: got %b exp 1", fetch_req); end
    n_cmp++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL hlt_rst_pc: got %h exp 0000", PC_out); end
  endtask

  task automatic test_reset_mid_exec;
    issue(16'h71FF); tick();  // PC 1
    issue(16'hC1CE); Z = 1'b1; RESET = 1'b1;  // would branch to FFFF
    tick(); RESET = 1'b0; Z = 1'b0;
    n_cmp++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL rst_exec_pc: got %h exp 0000", PC_out); end
    n_cmp++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL rst_exec_fetch_req: got %b exp 1", fetch_req); end
    n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL rst_exec_ctrwrd: got %h exp 0000", CTRWRD); end
    fetch_ack = 1'b1; IR_in = 16'h849D; RESET = 1'b1;  // pending fetch must be dropped
    tick(); RESET = 1'b0; fetch_ack = 1'b0; IR_in = 16'h0000;
    n_cmp++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_fetch_req: got %b exp 1", fetch_req); end
    n_cmp++; if (CTRWRD !== 16'h0000) begin n_fail++; $display("FAIL rst_fetch_ctrwrd: got %h exp 0000", CTRWRD); end
    n_cmp++; if (Cin !== 16'h0000) begin n_fail++; $display("FAIL rst_fetch_cin: got %h exp 0000", Cin); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_adi();
    test_load_store();
    test_nop();
    test_branch();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
